// File: rtl/pong_pkg.sv
// pong_pkg
// Shared types, display defaults and row-clamp helpers for the pong datapath.
// Optional feature macro used by importers: PADDLE_ACCEL_EN.
//   row_t       : one display row index
//   dir_e       : requested paddle direction for a motion tick
//   clamp_lo/hi : saturate a signed row computation against a bound
//   decode_dir  : map the up/down control pair to a direction
package pong_pkg;

    localparam int DEF_DISP_ROWS = 600;
    localparam int DEF_DISP_COLS = 800;
    localparam int DEF_ROW_W     = 12;

    typedef logic [DEF_ROW_W-1:0] row_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    function automatic int clamp_lo(input int value, input int lo);
        return (value < lo) ? lo : value;
    endfunction

    function automatic int clamp_hi(input int value, input int hi);
        return (value > hi) ? hi : value;
    endfunction

    // Both or neither pressed means "hold".
    function automatic dir_e decode_dir(input logic up, input logic down);
        if (up && !down) return DIR_UP;
        if (down && !up) return DIR_DOWN;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/paddle_motion_ctrl_if.sv
// paddle_motion_ctrl_if
// Player controls in, paddle rows / clamp flags / motion tick out.
//   move_up, move_down, recentre : one bit per paddle, driven by the master
//   paddle_center_row            : packed rows, paddle i at [i*ROW_W +: ROW_W]
//   at_top, at_bottom            : per-paddle clamp flags
//   tick                         : one-cycle motion strobe
// master = control source / consumer, slave = paddle_motion_ctrl.
interface paddle_motion_ctrl_if #(
    parameter int NUM_PADDLES = 2,
    parameter int ROW_W       = 12
);
    logic [NUM_PADDLES-1:0]       move_up;
    logic [NUM_PADDLES-1:0]       move_down;
    logic [NUM_PADDLES-1:0]       recentre;
    logic [NUM_PADDLES*ROW_W-1:0] paddle_center_row;
    logic [NUM_PADDLES-1:0]       at_top;
    logic [NUM_PADDLES-1:0]       at_bottom;
    logic                         tick;

    modport master (
        output move_up, move_down, recentre,
        input  paddle_center_row, at_top, at_bottom, tick
    );

    modport slave (
        input  move_up, move_down, recentre,
        output paddle_center_row, at_top, at_bottom, tick
    );
endinterface

// File: rtl/paddle_channel.sv
// paddle_channel
// Position, clamp flags and (optionally) acceleration state for one paddle.
// Macro PADDLE_ACCEL_EN enables the hold-to-accelerate step; without it the
// step is the constant STEP and no acceleration registers exist.
//   clk, rst          : clock, synchronous active-high reset
//   tick              : motion tick enable from the top level
//   move_up/move_down : direction controls, sampled on tick cycles only
//   recentre          : jump to screen centre on any cycle
//   center_row        : registered paddle centre row
//   at_top/at_bottom  : registered clamp flags, coincident with center_row
module paddle_channel
    import pong_pkg::*;
#(
    parameter int DISP_ROWS     = DEF_DISP_ROWS,
    parameter int ROW_W         = DEF_ROW_W,
    parameter int PADDLE_HEIGHT = 80,
    parameter int STEP          = 1
`ifdef PADDLE_ACCEL_EN
    ,
    parameter int ACCEL_HOLD    = 32,
    parameter int MAX_STEP      = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             move_up,
    input  logic             move_down,
    input  logic             recentre,
    output logic [ROW_W-1:0] center_row,
    output logic             at_top,
    output logic             at_bottom
);

    localparam int MIN_C = PADDLE_HEIGHT / 2;
    localparam int MAX_C = DISP_ROWS - PADDLE_HEIGHT / 2;
    localparam int CTR   = DISP_ROWS / 2;

    localparam logic [ROW_W-1:0] MIN_ROW  = ROW_W'(MIN_C);
    localparam logic [ROW_W-1:0] MAX_ROW  = ROW_W'(MAX_C);
    localparam logic [ROW_W-1:0] CTR_ROW  = ROW_W'(CTR);
    localparam logic [ROW_W-1:0] STEP_ROW = ROW_W'(STEP);

    dir_e                    dir;
    logic [ROW_W-1:0]        step_cur;
    logic [ROW_W-1:0]        pos_q;
    logic [ROW_W-1:0]        pos_nxt;
    logic                    at_top_q;
    logic                    at_bottom_q;
    logic signed [ROW_W:0]   pos_ext;
    logic signed [ROW_W:0]   step_ext;
    logic signed [ROW_W:0]   diff_ext;
    logic signed [ROW_W:0]   sum_ext;

    assign dir = decode_dir(move_up, move_down);

`ifdef PADDLE_ACCEL_EN
    localparam int HOLD_W = $clog2(ACCEL_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACCEL_HOLD - 1);

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_nxt;
    logic [ROW_W-1:0]  step_q;
    logic [ROW_W-1:0]  step_nxt;
    dir_e              dir_q;
    dir_e              dir_nxt;

    // The step chosen on a tick is the one used for that same tick's move,
    // so the first doubled step shows up on the tick that hits ACCEL_HOLD.
    always_comb begin
        hold_nxt = hold_q;
        step_nxt = step_q;
        dir_nxt  = dir_q;
        if (recentre) begin
            hold_nxt = '0;
            step_nxt = STEP_ROW;
            dir_nxt  = DIR_NONE;
        end else if (tick) begin
            dir_nxt = dir;
            if (dir == DIR_NONE || dir != dir_q) begin
                hold_nxt = '0;
                step_nxt = STEP_ROW;
            end else if (hold_q == HOLD_LAST) begin
                hold_nxt = '0;
                step_nxt = ROW_W'(clamp_hi(2 * int'(step_q), MAX_STEP));
            end else begin
                hold_nxt = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            step_q <= STEP_ROW;
            dir_q  <= DIR_NONE;
        end else begin
            hold_q <= hold_nxt;
            step_q <= step_nxt;
            dir_q  <= dir_nxt;
        end
    end

    assign step_cur = step_nxt;
`else
    assign step_cur = STEP_ROW;
`endif

    // One extra bit keeps pos - step from wrapping before the clamp.
    always_comb begin
        pos_ext  = $signed({1'b0, pos_q});
        step_ext = $signed({1'b0, step_cur});
        diff_ext = pos_ext - step_ext;
        sum_ext  = pos_ext + step_ext;
        pos_nxt  = pos_q;
        if (recentre) begin
            pos_nxt = CTR_ROW;
        end else if (tick) begin
            case (dir)
                DIR_UP:   pos_nxt = ROW_W'(clamp_lo(int'(diff_ext), MIN_C));
                DIR_DOWN: pos_nxt = ROW_W'(clamp_hi(int'(sum_ext), MAX_C));
                default:  pos_nxt = pos_q;
            endcase
        end
    end

    // Flags are derived from the next position so they change together
    // with center_row.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q       <= CTR_ROW;
            at_top_q    <= 1'b0;
            at_bottom_q <= 1'b0;
        end else begin
            pos_q       <= pos_nxt;
            at_top_q    <= (pos_nxt == MIN_ROW);
            at_bottom_q <= (pos_nxt == MAX_ROW);
        end
    end

    assign center_row = pos_q;
    assign at_top     = at_top_q;
    assign at_bottom  = at_bottom_q;

endmodule

// File: rtl/paddle_motion_ctrl.sv
// paddle_motion_ctrl
// Multi-paddle motion controller: divides clk into a motion tick and runs
// one paddle_channel per player. Row 0 is the top of the screen.
// Optional macro PADDLE_ACCEL_EN enables hold-to-accelerate in each channel.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : paddle_motion_ctrl_if.slave (controls in, rows/flags/tick out)
module paddle_motion_ctrl
    import pong_pkg::*;
#(
    parameter int DISP_ROWS     = DEF_DISP_ROWS,
    parameter int NUM_PADDLES   = 2,
    parameter int ROW_W         = DEF_ROW_W,
    parameter int PADDLE_HEIGHT = 80,
    parameter int TICK_DIV      = 40000,
    parameter int STEP          = 1,
    parameter int ACCEL_HOLD    = 32,
    parameter int MAX_STEP      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    paddle_motion_ctrl_if.slave  bus
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    // An illegal parameter set freezes the paddles at centre instead of
    // letting them wander outside the drawable area.
    localparam bit CFG_OK = (TICK_DIV >= 1) && (STEP >= 1) &&
                            (PADDLE_HEIGHT % 2 == 0) &&
                            (PADDLE_HEIGHT < DISP_ROWS) &&
                            (DISP_ROWS - 1 < (1 << ROW_W)) &&
                            (ACCEL_HOLD >= 1) && (MAX_STEP >= STEP);

    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_cnt_nxt;
    logic              tick_q;
    logic              tick_en;

    always_comb begin
        tick_cnt_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
    end

    // tick is registered from the next count so it is high exactly while
    // the counter holds TICK_DIV-1 (every cycle when TICK_DIV is 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            tick_q   <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt_nxt;
            tick_q   <= (tick_cnt_nxt == TICK_LAST);
        end
    end

    assign tick_en  = tick_q & CFG_OK;
    assign bus.tick = tick_en;

    for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_ch
        paddle_channel #(
            .DISP_ROWS     (DISP_ROWS),
            .ROW_W         (ROW_W),
            .PADDLE_HEIGHT (PADDLE_HEIGHT),
            .STEP          (STEP)
`ifdef PADDLE_ACCEL_EN
            ,
            .ACCEL_HOLD    (ACCEL_HOLD),
            .MAX_STEP      (MAX_STEP)
`endif
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick_en),
            .move_up    (bus.move_up[i]),
            .move_down  (bus.move_down[i]),
            .recentre   (bus.recentre[i]),
            .center_row (bus.paddle_center_row[i*ROW_W +: ROW_W]),
            .at_top     (bus.at_top[i]),
            .at_bottom  (bus.at_bottom[i])
        );
    end

endmodule
